spi_master_ctrl: RTL

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl_if.sv | 25 ++
 rtl/spi_master_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl_if.sv
// Request/response and pin bundle for the SPI master controller.
// The controller uses the master modport; the surrounding logic uses slave.
interface spi_master_ctrl_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       sclk_pin;
    logic       cs_pin;
    logic       mosi_pin;
    logic       miso_pin;

    modport master (
        input  start, rw, addr, wdata, miso_pin,
        output busy, done, rdata, sclk_pin, cs_pin, mosi_pin
    );

    modport slave (
        output start, rw, addr, wdata, miso_pin,
        input  busy, done, rdata, sclk_pin, cs_pin, mosi_pin
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master that issues one 7-bit address + R/W frame, followed by a write
// byte or a turnaround gap and a read byte, then a post phase and a CS-high gap.
module spi_master_ctrl #(
    parameter int HALF_PERIOD = 8,
    parameter int TURNAROUND  = 3,
    parameter int POST_CYCLES = 1
) (
    input logic               clk,
    input logic               reset,
    spi_master_ctrl_if.master bus
);
    localparam int DIV_W = $clog2(2 * HALF_PERIOD);
    localparam logic [DIV_W-1:0] RISE_AT  = DIV_W'(HALF_PERIOD - 1);
    localparam logic [DIV_W-1:0] SLOT_END = DIV_W'(2 * HALF_PERIOD - 1);

    localparam int MAX_SLOTS = (TURNAROUND > POST_CYCLES)
                             ? ((TURNAROUND > 8) ? TURNAROUND : 8)
                             : ((POST_CYCLES > 8) ? POST_CYCLES : 8);
    localparam int CNT_W = $clog2(MAX_SLOTS);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(6);
    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURNAROUND - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, RWBIT, WDATA, TURN, RDATA, POST, FIN
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [7:0]       tx_sh;
    logic [7:0]       rx_sh;
    logic [7:0]       wdata_q;
    logic             rw_q;
    logic             busy_q;
    logic             done_q;
    logic [7:0]       rdata_q;
    logic             sclk_q;
    logic             cs_q;
    logic             mosi_q;

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rdata    = rdata_q;
    assign bus.sclk_pin = sclk_q;
    assign bus.cs_pin   = cs_q;
    assign bus.mosi_pin = mosi_q;

    // tx_sh holds {addr, rw} and later the write byte; mosi always shows its MSB
    // and advances only on the clk where sclk falls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    tx_sh   <= {bus.addr, bus.rw};
                    rw_q    <= bus.rw;
                    wdata_q <= bus.wdata;
                    mosi_q  <= bus.addr[6];
                    cs_q    <= 1'b0;
                    busy_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    state   <= ADDR;
                end
            end else begin
                div_cnt <= (div_cnt == SLOT_END) ? '0 : div_cnt + 1'b1;

                if (div_cnt == RISE_AT && state != FIN) begin
                    sclk_q <= 1'b1;
                    if (state == RDATA) begin
                        rx_sh <= {rx_sh[6:0], bus.miso_pin};
                    end
                end

                if (div_cnt == SLOT_END) begin
                    sclk_q  <= 1'b0;
                    bit_cnt <= bit_cnt + 1'b1;
                    case (state)
                        ADDR: begin
                            tx_sh  <= {tx_sh[6:0], 1'b0};
                            mosi_q <= tx_sh[6];
                            if (bit_cnt == ADDR_LAST) begin
                                bit_cnt <= '0;
                                state   <= RWBIT;
                            end
                        end
                        RWBIT: begin
                            bit_cnt <= '0;
                            if (rw_q) begin
                                mosi_q <= 1'b0;
                                state  <= (TURNAROUND == 0) ? RDATA : TURN;
                            end else begin
                                tx_sh  <= wdata_q;
                                mosi_q <= wdata_q[7];
                                state  <= WDATA;
                            end
                        end
                        WDATA: begin
                            if (bit_cnt == BYTE_LAST) begin
                                mosi_q  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= (POST_CYCLES == 0) ? FIN : POST;
                                cs_q    <= (POST_CYCLES == 0);
                            end else begin
                                tx_sh  <= {tx_sh[6:0], 1'b0};
                                mosi_q <= tx_sh[6];
                            end
                        end
                        TURN: begin
                            if (bit_cnt == TURN_LAST) begin
                                bit_cnt <= '0;
                                state   <= RDATA;
                            end
                        end
                        RDATA: begin
                            if (bit_cnt == BYTE_LAST) begin
                                rdata_q <= rx_sh;
                                bit_cnt <= '0;
                                state   <= (POST_CYCLES == 0) ? FIN : POST;
                                cs_q    <= (POST_CYCLES == 0);
                            end
                        end
                        POST: begin
                            if (bit_cnt == POST_LAST) begin
                                bit_cnt <= '0;
                                cs_q    <= 1'b1;
                                state   <= FIN;
                            end
                        end
                        FIN: begin
                            bit_cnt <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule
